// File: rtl/axi4_slave_mem.sv
`timescale 1ns/1ps
// AXI4 slave backed by a 64-bit register-array memory. Handles one transaction at a time
// with INCR/FIXED bursts. WRAP/reserved bursts and out-of-range beats get SLVERR.
module axi4_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [3:0]              i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic [3:0]              o_bid,
    output logic [1:0]              o_bresp,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    input  logic [3:0]              i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    output logic [3:0]              o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WRESP = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic [7:0]              r_cnt;
    logic                    r_err;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    logic [3:0]              r_bid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [3:0]              r_rid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic [DATA_WIDTH-1:0]   r_mem [0:MEM_DEPTH-1];

    logic                    w_aw_hs;
    logic                    w_ar_hs;
    logic                    w_w_hs;
    logic                    w_w_err;
    logic                    w_w_last;
    logic                    w_wlast_err;
    logic [IDX_W-1:0]        w_widx;
    logic [ADDR_WIDTH-1:0]   w_next_addr;

    function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return burst[1] || (addr < BASE_ADDR) || ((off >> 3) >= ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] adv_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
        if (burst == 2'b00) begin
            return addr;
        end else begin
            return addr + (ADDR_WIDTH'(1) << size);
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [1:0] burst);
        if (beat_err(addr, burst)) begin
            return '0;
        end else begin
            return r_mem[word_idx(addr)];
        end
    endfunction

    assign w_aw_hs     = i_awvalid & r_awready;
    assign w_ar_hs     = i_arvalid & o_arready;
    assign w_w_hs      = i_wvalid & r_wready;
    assign w_w_err     = beat_err(r_addr, r_burst);
    assign w_w_last    = (r_cnt == r_len);
    assign w_wlast_err = w_w_last ? ~i_wlast : i_wlast;
    assign w_widx      = word_idx(r_addr);
    assign w_next_addr = adv_addr(r_addr, r_size, r_burst);

    // Write loses nothing to a simultaneous AR: AR readiness is masked by AW valid.
    assign o_awready = r_awready;
    assign o_arready = r_awready & ~i_awvalid;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bid     = r_bid;
    assign o_bresp   = r_bresp;
    assign o_rvalid  = r_rvalid;
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_rlast   = r_rlast;

    // Transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_id      <= 4'd0;
            r_addr    <= '0;
            r_len     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= 4'd0;
            r_bresp   <= 2'd0;
            r_rvalid  <= 1'b0;
            r_rid     <= 4'd0;
            r_rdata   <= '0;
            r_rresp   <= 2'd0;
            r_rlast   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id      <= i_awid;
                        r_addr    <= i_awaddr;
                        r_len     <= i_awlen;
                        r_size    <= i_awsize;
                        r_burst   <= i_awburst;
                        r_cnt     <= 8'd0;
                        r_err     <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_state   <= S_WDATA;
                    end else if (w_ar_hs) begin
                        r_id      <= i_arid;
                        r_addr    <= i_araddr;
                        r_len     <= i_arlen;
                        r_size    <= i_arsize;
                        r_burst   <= i_arburst;
                        r_cnt     <= 8'd0;
                        r_err     <= 1'b0;
                        r_awready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= i_arid;
                        r_rdata   <= rd_word(i_araddr, i_arburst);
                        r_rresp   <= beat_err(i_araddr, i_arburst) ? 2'b10 : 2'b00;
                        r_rlast   <= (i_arlen == 8'd0);
                        r_state   <= S_RDATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (w_w_hs) begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_addr <= w_next_addr;
                        if (w_w_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (r_err | w_w_err | w_wlast_err) ? 2'b10 : 2'b00;
                            r_state  <= S_WRESP;
                        end else begin
                            r_err <= r_err | w_w_err | w_wlast_err;
                        end
                    end
                end
                S_WRESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (i_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_awready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_cnt   <= r_cnt + 8'd1;
                            r_rdata <= rd_word(w_next_addr, r_burst);
                            r_rresp <= beat_err(w_next_addr, r_burst) ? 2'b10 : 2'b00;
                            r_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_WDATA) && w_w_hs && !w_w_err) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (i_wstrb[k]) begin
                    r_mem[w_widx][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
`timescale 1ns/1ps
// Self-checking bench for axi4_slave_mem: vector table, hand-built corner sequences and
// randomized traffic, all checked against a word-array reference memory.
module tb_axi4_slave_mem;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk, arst;
    logic        i_awvalid, o_awready;
    logic [3:0]  i_awid;
    logic [31:0] i_awaddr;
    logic [7:0]  i_awlen;
    logic [2:0]  i_awsize;
    logic [1:0]  i_awburst;
    logic        i_wvalid, o_wready;
    logic [63:0] i_wdata;
    logic [7:0]  i_wstrb;
    logic        i_wlast;
    logic        o_bvalid, i_bready;
    logic [3:0]  o_bid;
    logic [1:0]  o_bresp;
    logic        i_arvalid, o_arready;
    logic [3:0]  i_arid;
    logic [31:0] i_araddr;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic [1:0]  i_arburst;
    logic        o_rvalid, i_rready;
    logic [3:0]  o_rid;
    logic [63:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rlast;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem_m [0:255];
    logic [63:0] wd [0:255];
    logic [7:0]  ws [0:255];

    typedef struct {
        logic        wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [7:0]  wl_at;
        logic        pat;
        logic [63:0] data;
        int          rmode;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vt [NVEC];

    axi4_slave_mem dut (
        .clk(clk), .arst(arst),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
        .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .i_wlast(i_wlast),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
        .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
        .o_rresp(o_rresp), .o_rlast(o_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic bad_beat(input logic [31:0] a, input logic [1:0] burst);
        return burst[1] || (a < BASE) || (((a - BASE) / 32'd8) >= 32'd256);
    endfunction

    function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {50'd0, o_awready, o_arready, o_wready, o_bvalid, o_bid, o_bresp,
                             o_rvalid, o_rid, o_rresp, o_rlast}, 64'd0);
        chk({tag, "_rdata"}, o_rdata, 64'd0);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] wl_at,
                            input bit gaps, output logic [1:0] bresp_o);
        logic [31:0] a;
        logic        err;
        int          cyc;
        a   = addr;
        err = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (!bad_beat(a, burst)) begin
                for (int k = 0; k < 8; k++)
                    if (ws[b][k]) mem_m[int'((a - BASE) / 32'd8)][8*k +: 8] = wd[b][8*k +: 8];
            end
            err = err | bad_beat(a, burst);
            if (b == int'(len)) err = err | (int'(wl_at) != b);
            else                err = err | (int'(wl_at) == b);
            a = adv(a, size, burst);
        end
        @(negedge clk);
        i_awvalid = 1'b1; i_awid = id; i_awaddr = addr; i_awlen = len;
        i_awsize = size; i_awburst = burst;
        #1 chk("awready_idle", {63'd0, o_awready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (gaps && b > 0 && $urandom_range(0, 2) == 0) begin
                i_wvalid = 1'b0;
                @(posedge clk);
                @(negedge clk);
            end
            i_wvalid = 1'b1; i_wdata = wd[b]; i_wstrb = ws[b]; i_wlast = (int'(wl_at) == b);
            #1;
            if (b == 0) chk("wready_latency", {63'd0, o_wready}, 64'd1);
            cyc = 0;
            while (!o_wready && cyc < 20) begin
                @(negedge clk);
                #1 cyc++;
            end
            if (!o_wready) chk("wready_timeout", {63'd0, o_wready}, 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        #1;
        chk("bvalid_latency", {63'd0, o_bvalid}, 64'd1);
        chk("bid", {60'd0, o_bid}, {60'd0, id});
        chk("bresp_model", {62'd0, o_bresp}, {62'd0, err ? 2'b10 : 2'b00});
        bresp_o  = o_bresp;
        i_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_bready = 1'b0;
        #1 chk("bvalid_drop", {63'd0, o_bvalid}, 64'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode,
                           output logic [63:0] d0, output logic [1:0] r0);
        logic [31:0] a;
        logic [63:0] ed;
        logic        bad;
        logic        rr;
        int          b, cyc;
        logic        pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        d0  = 64'd0;
        r0  = 2'd0;
        @(negedge clk);
        i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arlen = len;
        i_arsize = size; i_arburst = burst;
        #1 chk("arready_idle", {63'd0, o_arready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_arvalid = 1'b0;
        a = addr; b = 0; cyc = 0;
        while (b <= int'(len) && cyc < 2000) begin
            if (rmode == 0)      rr = 1'b1;
            else if (rmode == 1) rr = 1'($urandom_range(0, 1));
            else                 rr = (cyc < 4) ? pat[cyc] : 1'b1;
            i_rready = rr;
            #1;
            bad = bad_beat(a, burst);
            ed  = bad ? 64'd0 : mem_m[int'((a - BASE) / 32'd8)];
            chk("rvalid", {63'd0, o_rvalid}, 64'd1);
            chk("rid", {60'd0, o_rid}, {60'd0, id});
            chk("rdata", o_rdata, ed);
            chk("rresp", {62'd0, o_rresp}, {62'd0, bad ? 2'b10 : 2'b00});
            chk("rlast", {63'd0, o_rlast}, {63'd0, b == int'(len)});
            if (b == 0) begin
                d0 = o_rdata;
                r0 = o_rresp;
            end
            @(posedge clk);
            @(negedge clk);
            if (rr) begin
                b++;
                a = adv(a, size, burst);
            end
            cyc++;
        end
        if (b <= int'(len)) chk("read_timeout", 64'(b), 64'(len) + 64'd1);
        i_rready = 1'b0;
        #1 chk("rvalid_drop", {63'd0, o_rvalid}, 64'd0);
    endtask

    initial begin
        logic [1:0]  bresp, r0;
        logic [63:0] d0;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] newd;

        vt[0]  = '{1'b1, 4'd5,  32'h4000_0000, 8'd7, 3'd3, 2'b01, 8'hFF, 8'd7,   1'b1, 64'd0, 0, 2'b00};
        vt[1]  = '{1'b0, 4'd5,  32'h4000_0000, 8'd7, 3'd3, 2'b01, 8'h00, 8'd0,   1'b0, 64'd0, 0, 2'b00};
        vt[2]  = '{1'b1, 4'd1,  32'h4000_0008, 8'd0, 3'd3, 2'b01, 8'hFF, 8'd0,   1'b0, 64'd0, 0, 2'b00};
        vt[3]  = '{1'b1, 4'd2,  32'h4000_000C, 8'd0, 3'd2, 2'b01, 8'hF0, 8'd0,   1'b0, 64'hDEADBEEF_00000000, 0, 2'b00};
        vt[4]  = '{1'b0, 4'd3,  32'h4000_0008, 8'd0, 3'd3, 2'b01, 8'h00, 8'd0,   1'b0, 64'd0, 0, 2'b00};
        vt[5]  = '{1'b0, 4'd4,  32'h4000_07F8, 8'd1, 3'd3, 2'b01, 8'h00, 8'd0,   1'b0, 64'd0, 0, 2'b00};
        vt[6]  = '{1'b1, 4'd6,  32'h4000_0040, 8'd3, 3'd3, 2'b01, 8'hFF, 8'd1,   1'b0, 64'h0123_4567_89AB_CDEF, 0, 2'b10};
        vt[7]  = '{1'b1, 4'd7,  32'h4000_0100, 8'd1, 3'd3, 2'b10, 8'hFF, 8'd1,   1'b0, 64'h5555_AAAA_5555_AAAA, 0, 2'b10};
        vt[8]  = '{1'b0, 4'd8,  32'h4000_0020, 8'd3, 3'd3, 2'b00, 8'h00, 8'd0,   1'b0, 64'd0, 1, 2'b00};
        vt[9]  = '{1'b1, 4'd9,  32'h3FFF_FFF8, 8'd1, 3'd3, 2'b01, 8'hFF, 8'd1,   1'b0, 64'hCAFE_F00D_0000_1234, 0, 2'b10};
        vt[10] = '{1'b1, 4'd10, 32'h4000_0080, 8'd0, 3'd3, 2'b01, 8'hFF, 8'hFF,  1'b0, 64'h7777_0000_7777_0000, 0, 2'b10};
        vt[11] = '{1'b0, 4'd11, 32'h4000_0080, 8'd0, 3'd3, 2'b11, 8'h00, 8'd0,   1'b0, 64'd0, 0, 2'b10};
        vt[12] = '{1'b0, 4'd12, 32'h4000_0000, 8'd3, 3'd3, 2'b01, 8'h00, 8'd0,   1'b0, 64'd0, 2, 2'b00};

        arst = 1'b1;
        i_awvalid = 1'b0; i_awid = 4'd0; i_awaddr = 32'd0; i_awlen = 8'd0; i_awsize = 3'd0; i_awburst = 2'd0;
        i_wvalid = 1'b0; i_wdata = 64'd0; i_wstrb = 8'd0; i_wlast = 1'b0; i_bready = 1'b0;
        i_arvalid = 1'b0; i_arid = 4'd0; i_araddr = 32'd0; i_arlen = 8'd0; i_arsize = 3'd0; i_arburst = 2'd0;
        i_rready = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        arst = 1'b0;
        @(negedge clk);
        #1 chk("awready_after_reset", {63'd0, o_awready}, 64'd1);

        // fill the whole memory so every later read has a known value
        for (int b = 0; b < 256; b++) begin
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        do_write(4'd0, BASE, 8'd255, 3'd3, 2'b01, 8'd255, 1'b0, bresp);

        for (int i = 0; i < NVEC; i++) begin
            if (vt[i].wr) begin
                for (int b = 0; b <= int'(vt[i].len); b++) begin
                    wd[b] = vt[i].pat ? 64'(b + 1) * 64'h1111_1111_1111_1111
                                      : ((b == 0) ? vt[i].data : {$urandom, $urandom});
                    ws[b] = vt[i].strb;
                end
                do_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].wl_at, 1'b0, bresp);
                chk("tbl_bresp", {62'd0, bresp}, {62'd0, vt[i].exp_resp});
            end else begin
                do_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].rmode, d0, r0);
                chk("tbl_rresp0", {62'd0, r0}, {62'd0, vt[i].exp_resp});
                if (i == 1) chk("incr_beat0", d0, 64'h1111_1111_1111_1111);
                if (i == 4) chk("narrow_strobe", d0, 64'hDEADBEEF_00000000);
            end
        end

        // simultaneous AW and AR: write wins, the read waits and sees the new data
        newd = {$urandom, $urandom};
        @(negedge clk);
        i_awvalid = 1'b1; i_awid = 4'd3; i_awaddr = BASE + 32'h300; i_awlen = 8'd0; i_awsize = 3'd3; i_awburst = 2'b01;
        i_arvalid = 1'b1; i_arid = 4'd9; i_araddr = BASE + 32'h300; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'b01;
        #1;
        chk("sim_awready", {63'd0, o_awready}, 64'd1);
        chk("sim_arready", {63'd0, o_arready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b1; i_wdata = newd; i_wstrb = 8'hFF; i_wlast = 1'b1;
        #1 chk("sim_arready_wdata", {63'd0, o_arready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        mem_m[8'h60] = newd;
        i_wvalid = 1'b0; i_wlast = 1'b0; i_bready = 1'b1;
        #1;
        chk("sim_bvalid", {63'd0, o_bvalid}, 64'd1);
        chk("sim_arready_wresp", {63'd0, o_arready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        i_bready = 1'b0;
        #1 chk("sim_arready_after_b", {63'd0, o_arready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        i_arvalid = 1'b0; i_rready = 1'b1;
        #1;
        chk("sim_rvalid", {63'd0, o_rvalid}, 64'd1);
        chk("sim_rdata", o_rdata, newd);
        @(posedge clk);
        @(negedge clk);
        i_rready = 1'b0;

        // reset after 3 of 8 write beats
        for (int b = 0; b < 8; b++) wd[b] = {$urandom, $urandom};
        @(negedge clk);
        i_awvalid = 1'b1; i_awid = 4'd7; i_awaddr = BASE + 32'h200; i_awlen = 8'd7; i_awsize = 3'd3; i_awburst = 2'b01;
        @(posedge clk);
        @(negedge clk);
        i_awvalid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            i_wvalid = 1'b1; i_wdata = wd[b]; i_wstrb = 8'hFF; i_wlast = 1'b0;
            mem_m[64 + b] = wd[b];
            @(posedge clk);
            @(negedge clk);
        end
        i_wdata = wd[3];
        arst = 1'b1;
        #1 check_all_zero("midburst_reset");
        repeat (2) @(negedge clk);
        arst = 1'b0; i_wvalid = 1'b0;
        @(negedge clk);
        #1 chk("awready_after_midburst", {63'd0, o_awready}, 64'd1);
        do_read(4'd1, BASE + 32'h200, 8'd7, 3'd3, 2'b01, 0, d0, r0);

        // randomized traffic against the reference memory
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       addr = BASE - 32'd8 * 32'($urandom_range(1, 4));
                1:       addr = BASE + 32'h7C0 + 32'd8 * 32'($urandom_range(0, 7));
                default: addr = BASE + (32'($urandom_range(0, 255)) << 3);
            endcase
            size = 3'($urandom_range(0, 3));
            addr = addr | (32'($urandom_range(0, 7)) & ~((32'd1 << size) - 32'd1));
            len  = 8'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       burst = 2'b00;
                1:       burst = 2'($urandom_range(2, 3));
                default: burst = 2'b01;
            endcase
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= int'(len); b++) begin
                    wd[b] = {$urandom, $urandom};
                    ws[b] = 8'($urandom);
                end
                do_write(4'($urandom), addr, len, size, burst,
                         ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 7)) : len, 1'b1, bresp);
            end else begin
                do_read(4'($urandom), addr, len, size, burst, 1, d0, r0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
